vfifo_sc_ctrl: RTL and testbench

- Single-clock FIFO controller placed directly upstream of vfifo_dual_port_ram_sc_dw, which it drives as a simple dual-port RAM.
- RAM port A is the write port; RAM port B is the read port, with we_b tied low.
- Exposes valid/ready streams on both sides and presents data first-word-fall-through, directly from the RAM's registered q_b.
- Provides occupancy count, almost-full/almost-empty flags and a synchronous flush.

---
 rtl/vfifo_sc_ctrl.sv | 84 ++++++++
 tb/tb_vfifo_sc_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vfifo_sc_ctrl.sv
// Single-clock FIFO controller that drives a simple dual-port RAM (port A writes, port B reads).
// The head word is presented first-word-fall-through straight from the RAM's registered q_b.
module vfifo_sc_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int AFULL_LVL  = 2**ADDR_WIDTH-2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_next_s;
  logic [PW-1:0] count_s;
  logic          m_valid_r;
  logic          full_s;
  logic          s_ready_s;
  logic          push_s;
  logic          pop_s;

  assign count_s   = wr_ptr_r - rd_ptr_r;
  assign full_s    = (count_s == DEPTH_C);
  // Flush blocks a same-cycle write so the cleared FIFO stays empty.
  assign s_ready_s = ~full_s & ~flush;
  assign push_s    = s_valid & s_ready_s;
  assign pop_s     = m_valid_r & m_ready;
  assign rd_next_s = rd_ptr_r + {{ADDR_WIDTH{1'b0}}, pop_s};

  assign s_ready      = s_ready_s;
  assign count        = count_s;
  assign almost_full  = (count_s >= AFULL_C);
  assign almost_empty = (count_s <= AEMPTY_C);
  assign m_valid      = m_valid_r;
  assign m_data       = ram_q_b;

  // The read address leads rd_ptr so the RAM latches the new head on the popping edge.
  assign ram_we_a  = push_s;
  assign ram_adr_a = wr_ptr_r[ADDR_WIDTH-1:0];
  assign ram_d_a   = s_data;
  assign ram_adr_b = rd_next_s[ADDR_WIDTH-1:0];
  assign ram_we_b  = 1'b0;

  // Pointer and head-valid registers; flush has priority over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      m_valid_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      m_valid_r <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_r + {{ADDR_WIDTH{1'b0}}, push_s};
      rd_ptr_r  <= rd_next_s;
      // Comparing with the pre-edge wr_ptr hides a word until the RAM can return it.
      m_valid_r <= (rd_next_s != wr_ptr_r);
    end
  end

endmodule

// File: tb/tb_vfifo_sc_ctrl.sv
// Randomised scoreboard bench for vfifo_sc_ctrl with a behavioural RAM (old data on read-during-write).
module tb_vfifo_sc_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic [AW-1:0] ram_adr_a;
  logic [DW-1:0] ram_d_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_adr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_q_b;

  vfifo_sc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(2), .AEMPTY_LVL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_adr_a(ram_adr_a), .ram_d_a(ram_d_a), .ram_we_a(ram_we_a),
    .ram_adr_b(ram_adr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM: registered read returns the old word on an address collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } entry_t;

  entry_t q[$];
  int cyc = 0;
  int wr_total = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor/scoreboard: a word accepted in cycle w must be visible no earlier than cycle w+2.
  always @(negedge clk) begin
    int  n;
    logic exp_sready, exp_mvalid;
    if (!rst_n) begin
      q.delete();
      wr_total = 0;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_ram_adr_b", 32'(ram_adr_b), 32'd0);
    end else begin
      n = q.size();
      exp_sready = (n != DEPTH) && !flush;
      exp_mvalid = (n > 0) && (q[0].cyc + 2 <= cyc);
      chk("count", 32'(count), 32'(n));
      chk("s_ready", 32'(s_ready), 32'(exp_sready));
      chk("almost_full", 32'(almost_full), 32'(n >= 2));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
      chk("m_valid", 32'(m_valid), 32'(exp_mvalid));
      if (exp_mvalid) chk("m_data", 32'(m_data), 32'(q[0].data));
      chk("ram_we_a", 32'(ram_we_a), 32'(s_valid && exp_sready));
      chk("ram_we_b", 32'(ram_we_b), 32'd0);
      if (s_valid && exp_sready) begin
        chk("ram_adr_a", 32'(ram_adr_a), 32'(wr_total % DEPTH));
        chk("ram_d_a", 32'(ram_d_a), 32'(s_data));
      end
      if (flush) begin
        q.delete();
        wr_total = 0;
      end else begin
        if (exp_mvalid && m_ready) void'(q.pop_front());
        if (s_valid && exp_sready) begin
          q.push_back('{data: s_data, cyc: cyc});
          wr_total++;
        end
      end
    end
  end

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // First-word latency
    s_valid = 1'b1; s_data = 8'hA1; step(1);
    s_valid = 1'b0; step(3);
    m_ready = 1'b1; step(2); m_ready = 1'b0;

    // Fill to full; the fifth word must be refused
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h10 + i); step(1);
    end
    s_valid = 1'b0; step(2);

    // Drain a full FIFO back-to-back
    m_ready = 1'b1; step(6); m_ready = 1'b0;

    // Steady stream across pointer wrap
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; m_ready = 1'b1; s_data = 8'(i); step(1);
    end
    s_valid = 1'b0; step(4); m_ready = 1'b0;

    // Stall with pushes continuing until full
    s_valid = 1'b1; s_data = 8'h55; step(1); s_data = 8'h66; step(1);
    s_valid = 1'b0; step(2);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hC0 + i); step(1);
    end
    s_valid = 1'b0; m_ready = 1'b1; step(6); m_ready = 1'b0;

    // Flush together with push and pop at count 3
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h30 + i); step(1);
    end
    s_valid = 1'b0; step(2);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1; step(1);
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; step(3);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h70 + i); step(1);
    end
    s_valid = 1'b0; step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_m_valid", 32'(m_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_s_ready", 32'(s_ready), 32'd1);
    chk("async_almost_empty", 32'(almost_empty), 32'd1);
    chk("async_almost_full", 32'(almost_full), 32'd0);
    chk("async_ram_we_a", 32'(ram_we_a), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      s_valid = 1'($urandom_range(0, 3) != 0);
      m_ready = 1'($urandom_range(0, 2) != 0);
      s_data  = 8'($urandom);
      flush   = 1'($urandom_range(0, 60) == 0);
      step(1);
    end
    s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1; step(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
